// File: rtl/alu_op_controller_if.sv
// Control bundle between the instruction source and the ALU-instruction sequencer.
// The source side uses master; the sequencer uses slave.
interface alu_op_controller_if #(
  parameter int WIDTH = 16
);
  logic             s;
  logic [15:0]      instr;
  logic             w;
  logic             done;
  logic             err;
  logic [2:0]       readnum;
  logic [2:0]       writenum;
  logic             write;
  logic             loada;
  logic             loadb;
  logic             loadc;
  logic             loads;
  logic             asel;
  logic [1:0]       vsel;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] sximm8;

  modport master (
    output s, instr,
    input  w, done, err, readnum, writenum, write,
    input  loada, loadb, loadc, loads, asel, vsel, ALUop, sximm8
  );

  modport slave (
    input  s, instr,
    output w, done, err, readnum, writenum, write,
    output loada, loadb, loadc, loads, asel, vsel, ALUop, sximm8
  );
endinterface

// File: rtl/alu_op_controller.sv
// Multi-cycle sequencer for one 16-bit ALU-class instruction at a time:
// Moore FSM driving regfile selects, A/B/C/status loads, operand muxes and ALUop.
module alu_op_controller #(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 reset,
  alu_op_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_WAIT, ST_GET_A, ST_GET_B, ST_EXEC, ST_WB, ST_WIMM, ST_ERR
  } state_t;

  typedef enum logic [2:0] {
    C_ADD, C_CMP, C_AND, C_MVN, C_MOV, C_MOVI, C_ILL
  } cls_t;

  state_t      state, state_nx;
  logic [15:0] ir;
  cls_t        ir_cls;

  logic             w_c, done_c, err_c, write_c;
  logic             loada_c, loadb_c, loadc_c, loads_c, asel_c;
  logic [2:0]       readnum_c, writenum_c;
  logic [1:0]       vsel_c, aluop_c;

  function automatic cls_t classify(input logic [15:0] ins);
    cls_t c;
    c = C_ILL;
    if (ins[15:13] == 3'b101) begin
      case (ins[12:11])
        2'b00:   c = C_ADD;
        2'b01:   c = C_CMP;
        2'b10:   c = C_AND;
        default: c = C_MVN;
      endcase
    end else if (ins[15:13] == 3'b110) begin
      if (ins[12:11] == 2'b00)      c = C_MOV;
      else if (ins[12:11] == 2'b10) c = C_MOVI;
    end
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] sign_extend8(input logic [7:0] imm);
    return {{(WIDTH-8){imm[7]}}, imm};
  endfunction

  assign ir_cls = classify(ir);

  // State and instruction register; ir only loads on acceptance in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_WAIT && bus.s) ir <= bus.instr;
    end
  end

  always_comb begin
    state_nx   = state;
    w_c        = 1'b0;
    done_c     = 1'b0;
    err_c      = 1'b0;
    write_c    = 1'b0;
    loada_c    = 1'b0;
    loadb_c    = 1'b0;
    loadc_c    = 1'b0;
    loads_c    = 1'b0;
    asel_c     = 1'b0;
    readnum_c  = 3'd0;
    writenum_c = 3'd0;
    vsel_c     = 2'b00;
    aluop_c    = 2'b00;
    case (state)
      ST_WAIT: begin
        w_c = 1'b1;
        if (bus.s) begin
          case (classify(bus.instr))
            C_ADD, C_AND, C_CMP: state_nx = ST_GET_A;
            C_MVN, C_MOV:        state_nx = ST_GET_B;
            C_MOVI:              state_nx = ST_WIMM;
            default:             state_nx = ST_ERR;
          endcase
        end
      end
      ST_GET_A: begin
        readnum_c = ir[10:8];
        loada_c   = 1'b1;
        state_nx  = ST_GET_B;
      end
      ST_GET_B: begin
        readnum_c = ir[2:0];
        loadb_c   = 1'b1;
        state_nx  = ST_EXEC;
      end
      ST_EXEC: begin
        loadc_c = 1'b1;
        // MOV runs as 0 + B through the adder; opcode 101 forwards op as ALUop.
        if (ir[15:13] == 3'b101) begin
          aluop_c = ir[12:11];
          loads_c = 1'b1;
        end
        asel_c = (ir_cls == C_MVN) || (ir_cls == C_MOV);
        if (ir_cls == C_CMP) begin
          done_c   = 1'b1;
          state_nx = ST_WAIT;
        end else begin
          state_nx = ST_WB;
        end
      end
      ST_WB: begin
        writenum_c = ir[7:5];
        write_c    = 1'b1;
        done_c     = 1'b1;
        state_nx   = ST_WAIT;
      end
      ST_WIMM: begin
        writenum_c = ir[7:5];
        vsel_c     = 2'b10;
        write_c    = 1'b1;
        done_c     = 1'b1;
        state_nx   = ST_WAIT;
      end
      ST_ERR: begin
        err_c    = 1'b1;
        done_c   = 1'b1;
        state_nx = ST_WAIT;
      end
      default: state_nx = ST_WAIT;
    endcase
  end

  assign bus.w        = w_c;
  assign bus.done     = done_c;
  assign bus.err      = err_c;
  assign bus.readnum  = readnum_c;
  assign bus.writenum = writenum_c;
  assign bus.write    = write_c;
  assign bus.loada    = loada_c;
  assign bus.loadb    = loadb_c;
  assign bus.loadc    = loadc_c;
  assign bus.loads    = loads_c;
  assign bus.asel     = asel_c;
  assign bus.vsel     = vsel_c;
  assign bus.ALUop    = aluop_c;
  assign bus.sximm8   = sign_extend8(ir[7:0]);

endmodule

// File: tb/tb_alu_op_controller.sv
// Directed bench for alu_op_controller: per-cycle strobe vectors for each
// instruction class, reset abort, ignored start and back-to-back issue.
module tb_alu_op_controller;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_op_controller_if #(.WIDTH(WIDTH)) bus ();

  alu_op_controller #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {w,done,err,readnum,writenum,write,loada,loadb,loadc,loads,asel,vsel,ALUop}
  function automatic logic [18:0] v(bit w_, bit dn, bit er, logic [2:0] rn, logic [2:0] wn,
                                    bit wr, bit la, bit lb, bit lc, bit ls, bit as,
                                    logic [1:0] vs, logic [1:0] op);
    return {w_, dn, er, rn, wn, wr, la, lb, lc, ls, as, vs, op};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.w, bus.done, bus.err, bus.readnum, bus.writenum, bus.write,
            bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.vsel, bus.ALUop};
  endfunction

  logic [18:0] WAITV;

  task automatic issue(input logic [15:0] ins);
    bus.s     = 1'b1;
    bus.instr = ins;
  endtask

  task automatic test_reset();
    bus.s     = 1'b0;
    bus.instr = 16'h0000;
    reset     = 1'b1;
    #2;
    n_cmp++;
    if (obs() !== WAITV) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected %h", obs(), WAITV);
    end
    n_cmp++;
    if (bus.sximm8 !== 16'h0000) begin
      n_bad++; $display("FAIL reset_sximm8: got %h expected 0000", bus.sximm8);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== WAITV) begin
      n_bad++; $display("FAIL reset_release: got %h expected %h", obs(), WAITV);
    end
  endtask

  task automatic test_add();
    logic [18:0] e[5];
    e = '{v(0,0,0,3'd0,3'd0,0,1,0,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd2,3'd0,0,0,1,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd0,3'd0,0,0,0,1,1,0,2'b00,2'b00),
          v(0,1,0,3'd0,3'd5,1,0,0,0,0,0,2'b00,2'b00),
          WAITV};
    issue(16'hA0A2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.s = 1'b0;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++; $display("FAIL add_cyc%0d: got %h expected %h", i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_cmp();
    logic [18:0] e[4];
    e = '{v(0,0,0,3'd1,3'd0,0,1,0,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd0,3'd0,0,0,1,0,0,0,2'b00,2'b00),
          v(0,1,0,3'd0,3'd0,0,0,0,1,1,0,2'b00,2'b01),
          WAITV};
    issue(16'hA900);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.s = 1'b0;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++; $display("FAIL cmp_cyc%0d: got %h expected %h", i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_movi(input logic [15:0] ins, input logic [2:0] rd, input logic [15:0] sx);
    logic [18:0] e[2];
    e = '{v(0,1,0,3'd0,rd,1,0,0,0,0,0,2'b10,2'b00), WAITV};
    issue(ins);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.s     = 1'b0;
      bus.instr = 16'h0000;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++; $display("FAIL movi_%h_cyc%0d: got %h expected %h", ins, i + 1, obs(), e[i]);
      end
      n_cmp++;
      if (bus.sximm8 !== sx) begin
        n_bad++; $display("FAIL movi_%h_sximm8: got %h expected %h", ins, bus.sximm8, sx);
      end
    end
  endtask

  task automatic test_mvn_mov(input logic [15:0] ins, input bit ls, input logic [1:0] op);
    logic [18:0] e[4];
    e = '{v(0,0,0,3'd4,3'd0,0,0,1,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd0,3'd0,0,0,0,1,ls,1,2'b00,op),
          v(0,1,0,3'd0,3'd1,1,0,0,0,0,0,2'b00,2'b00),
          WAITV};
    issue(ins);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.s = 1'b0;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++; $display("FAIL unary_%h_cyc%0d: got %h expected %h", ins, i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_illegal(input logic [15:0] ins);
    logic [18:0] e[2];
    e = '{v(0,1,1,3'd0,3'd0,0,0,0,0,0,0,2'b00,2'b00), WAITV};
    issue(ins);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.s = 1'b0;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++; $display("FAIL illegal_%h_cyc%0d: got %h expected %h", ins, i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [18:0] e[6];
    e = '{v(0,0,0,3'd0,3'd0,0,1,0,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd2,3'd0,0,0,1,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd0,3'd0,0,0,0,1,1,0,2'b00,2'b00),
          v(0,1,0,3'd0,3'd5,1,0,0,0,0,0,2'b00,2'b00),
          WAITV, WAITV};
    issue(16'hA0A2);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      // Start pulse with a MOVI lands on the edge leaving GET_B.
      if (i == 1) issue(16'hD07F);
      else        bus.s = 1'b0;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++; $display("FAIL ignored_s_cyc%0d: got %h expected %h", i + 1, obs(), e[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [18:0] e[3];
    e = '{v(0,0,0,3'd0,3'd0,0,1,0,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd2,3'd0,0,0,1,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd0,3'd0,0,0,0,1,1,0,2'b00,2'b00)};
    issue(16'hA0A2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.s = 1'b0;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++; $display("FAIL abort_cyc%0d: got %h expected %h", i + 1, obs(), e[i]);
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== WAITV) begin
      n_bad++; $display("FAIL abort_async: got %h expected %h", obs(), WAITV);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs() !== WAITV) begin
        n_bad++; $display("FAIL abort_after_%0d: got %h expected %h", i, obs(), WAITV);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] e[9];
    e = '{v(0,0,0,3'd0,3'd0,0,1,0,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd2,3'd0,0,0,1,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd0,3'd0,0,0,0,1,1,0,2'b00,2'b00),
          v(0,1,0,3'd0,3'd5,1,0,0,0,0,0,2'b00,2'b00),
          WAITV,
          v(0,0,0,3'd0,3'd0,0,1,0,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd2,3'd0,0,0,1,0,0,0,2'b00,2'b00),
          v(0,0,0,3'd0,3'd0,0,0,0,1,1,0,2'b00,2'b00),
          v(0,1,0,3'd0,3'd5,1,0,0,0,0,0,2'b00,2'b00)};
    issue(16'hA0A2);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 5) bus.s = 1'b0;
      n_cmp++;
      if (obs() !== e[i]) begin
        n_bad++; $display("FAIL b2b_cyc%0d: got %h expected %h", i + 1, obs(), e[i]);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (obs() !== WAITV) begin
      n_bad++; $display("FAIL b2b_idle: got %h expected %h", obs(), WAITV);
    end
  endtask

  initial begin
    WAITV = v(1,0,0,3'd0,3'd0,0,0,0,0,0,0,2'b00,2'b00);
    test_reset();
    test_add();
    test_cmp();
    test_movi(16'hD3F0, 3'd7, 16'hFFF0);
    test_movi(16'hD07F, 3'd3, 16'h007F);
    test_mvn_mov(16'hB824, 1'b1, 2'b11);
    test_mvn_mov(16'hC024, 1'b0, 2'b00);
    test_illegal(16'hE000);
    test_illegal(16'hC800);
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
